// File: rtl/controllo_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, OP classes,
// and the datapath mux select codes driven by the controller.
package controllo_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        FAULT    = 4'd10
    } state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_RD2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    // Register-file read address steering; this is pure instruction decode.
    function automatic logic [1:0] regsrc_f(input logic [1:0] op, input logic load);
        return {(op == OP_MEM) && !load, op == OP_BR};
    endfunction

endpackage

// File: rtl/controllo_multiciclo_mem_watchdog.sv
// Memory-wait watchdog: counts consecutive stalled request cycles and flags
// the cycle in which the count reaches MEM_TIMEOUT (0 disables the check).
module mem_watchdog #(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (wait_i && !clr_i)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Fires on the stall cycle that brings the count up to the limit.
    always_comb begin
        expire_o = 1'b0;
        if (MEM_TIMEOUT != 0 && wait_i)
            expire_o = (int'(cnt_q) + 1) >= MEM_TIMEOUT;
    end

endmodule

// File: rtl/controllo_multiciclo.sv
// Multicycle ARM-subset control FSM with memory handshake, watchdog and
// condition gating. Optional perf counters under `CTRL_PERF_EN.
module controllo_multiciclo
    import controllo_pkg::*;
#(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        OP,
    input  logic [5:0]        Funct,
    input  logic              CondEx,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemW,
    output logic              IRWrite,
    output logic              RegW,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              ALUOp,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic              instr_done,
    output logic              fault,
    output logic [PERF_W-1:0] instr_count,
    output logic [PERF_W-1:0] cycle_count
);

    state_e state_q, state_d;
    logic   req_s, memw_s, regw_s, pcw_s, irw_s, done_s;
    logic   wait_s, expire_s, state_chg_s;
    logic   unused_funct;

    // cmd bits are consumed by the ALU decoder, not by this FSM
    assign unused_funct = ^Funct[4:1];

    assign wait_s      = req_s && !mem_ready;
    assign state_chg_s = (state_d != state_q);

    mem_watchdog #(
        .TIMEOUT_W  (TIMEOUT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (reset_n),
        .wait_i  (wait_s),
        .clr_i   (state_chg_s),
        .expire_o(expire_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_s     = 1'b0;
        memw_s    = 1'b0;
        regw_s    = 1'b0;
        pcw_s     = 1'b0;
        irw_s     = 1'b0;
        done_s    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ALUOp     = 1'b0;
        unique case (state_q)
            FETCH: begin
                req_s     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALURES;
                irw_s     = mem_ready;
                pcw_s     = mem_ready;
                if (expire_s)       state_d = FAULT;
                else if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALURES;
                if (!CondEx || OP == 2'b11) begin
                    done_s  = 1'b1;
                    state_d = FETCH;
                end else if (OP == OP_MEM) state_d = MEMADR;
                else if (OP == OP_BR)      state_d = BRANCH;
                else                       state_d = Funct[5] ? EXECI : EXECR;
            end
            MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                req_s  = 1'b1;
                AdrSrc = 1'b1;
                if (expire_s)       state_d = FAULT;
                else if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                regw_s    = 1'b1;
                done_s    = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                req_s  = 1'b1;
                memw_s = 1'b1;
                AdrSrc = 1'b1;
                if (expire_s) state_d = FAULT;
                else if (mem_ready) begin
                    done_s  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECR: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                regw_s  = 1'b1;
                done_s  = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                pcw_s     = 1'b1;
                done_s    = 1'b1;
                state_d   = FETCH;
            end
            FAULT:   state_d = FAULT;
            default: state_d = FETCH;
        endcase
    end

    // Strobes are gated by reset directly so an access in flight dies at once.
    assign mem_req    = req_s  && reset_n;
    assign MemW       = memw_s && reset_n;
    assign RegW       = regw_s && reset_n;
    assign PCWrite    = pcw_s  && reset_n;
    assign IRWrite    = irw_s  && reset_n;
    assign instr_done = done_s && reset_n;
    assign fault      = (state_q == FAULT);

    assign ImmSrc = fault ? 2'b00 : OP;
    assign RegSrc = fault ? 2'b00 : regsrc_f(OP, Funct[0]);

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] icnt_q, ccnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icnt_q <= '0;
            ccnt_q <= '0;
        end else begin
            ccnt_q <= ccnt_q + 1'b1;
            if (done_s) icnt_q <= icnt_q + 1'b1;
        end
    end

    assign instr_count = icnt_q;
    assign cycle_count = ccnt_q;
`else
    assign instr_count = '0;
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_controllo_multiciclo.sv
// Randomized bench for controllo_multiciclo: per-instruction totals checked
// against latency/side-effect rules, plus watchdog, reset and perf scenarios.
module tb_controllo_multiciclo;

    logic        clk, reset_n;
    logic [1:0]  OP;
    logic [5:0]  Funct;
    logic        CondEx, mem_ready;
    logic        mem_req, PCWrite, AdrSrc, MemW, IRWrite, RegW;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic        ALUSrcA, ALUOp, instr_done, fault;
    logic [31:0] instr_count, cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    controllo_multiciclo dut (
        .clk(clk), .reset_n(reset_n), .OP(OP), .Funct(Funct), .CondEx(CondEx),
        .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemW(MemW), .IRWrite(IRWrite), .RegW(RegW), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .instr_done(instr_done), .fault(fault),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs one instruction starting at a negedge with the FSM in FETCH.
    // The memory model inserts wf stall cycles on fetch and wm on the data access.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic cx,
                             input int wf, input int wm);
        int  cyc, acc, wc, tgt;
        int  n_req, n_memw, n_regw, n_pcw, n_irw, n_done, n_adr, n_aluop, bad_dec;
        int  rs_wb, br_srcb, br_rs;
        bit  done, exec, is_mem, is_ld, is_st, is_dp, is_br;
        int  exp_lat;
        OP = op; Funct = fn; CondEx = cx;
        cyc = 0; acc = 0; wc = 0; done = 0;
        n_req = 0; n_memw = 0; n_regw = 0; n_pcw = 0; n_irw = 0; n_done = 0;
        n_adr = 0; n_aluop = 0; bad_dec = 0; rs_wb = -1; br_srcb = -1; br_rs = -1;
        while (!done && cyc < 80) begin
            if (mem_req) begin
                tgt = (acc == 0) ? wf : wm;
                mem_ready = (wc >= tgt);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            if (mem_req) n_req++;
            if (MemW) n_memw++;
            if (RegW) begin n_regw++; rs_wb = ResultSrc; end
            if (PCWrite) begin
                n_pcw++;
                if (!mem_req) begin br_srcb = ALUSrcB; br_rs = ResultSrc; end
            end
            if (IRWrite) n_irw++;
            if (mem_req && AdrSrc) n_adr++;
            if (ALUOp) n_aluop++;
            if (ImmSrc != op || RegSrc != {op == 2'b01 && !fn[0], op == 2'b10}) bad_dec++;
            if (instr_done) begin n_done++; done = 1; end
            if (mem_req) begin
                if (mem_ready) begin acc++; wc = 0; end
                else wc++;
            end
            @(negedge clk);
        end
        exec   = cx && (op != 2'b11);
        is_dp  = exec && op == 2'b00;
        is_br  = exec && op == 2'b10;
        is_mem = exec && op == 2'b01;
        is_ld  = is_mem && fn[0];
        is_st  = is_mem && !fn[0];
        exp_lat = !exec ? 2 : is_dp ? 4 : is_br ? 3 : is_ld ? 5 + wm : 4 + wm;
        exp_lat += wf;
        chk("latency", cyc, exp_lat);
        chk("instr_done", n_done, 1);
        chk("irwrite", n_irw, 1);
        chk("mem_req_cycles", n_req, 1 + wf + (is_mem ? 1 + wm : 0));
        chk("adrsrc_cycles", n_adr, is_mem ? 1 + wm : 0);
        chk("memw_cycles", n_memw, is_st ? 1 + wm : 0);
        chk("regw_cycles", n_regw, (is_dp || is_ld) ? 1 : 0);
        chk("pcwrite_cycles", n_pcw, is_br ? 2 : 1);
        chk("aluop_cycles", n_aluop, is_dp ? 1 : 0);
        chk("immsrc_regsrc", bad_dec, 0);
        if (is_dp || is_ld) chk("wb_resultsrc", rs_wb, is_ld ? 1 : 0);
        if (is_br) begin
            chk("br_alusrcb", br_srcb, 1);
            chk("br_resultsrc", br_rs, 2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, want 0");
        $fatal(1, "timeout");
    end

    initial begin
        int k, n;
        reset_n = 1'b0; mem_ready = 1'b1; OP = 2'b00; Funct = 6'd0; CondEx = 1'b1;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_done", instr_done, 0);
        chk("rst_fault", fault, 0);
        do_reset();
        #1;
        chk("fetch_req", mem_req, 1);
        chk("fetch_resultsrc", ResultSrc, 2);
        chk("fetch_alusrcb", ALUSrcB, 2);
        @(negedge clk);

        // directed: ADD, LDR with 3 waits, skipped STR, branch
        run_instr(2'b00, 6'b000000, 1'b1, 0, 0);
        run_instr(2'b01, 6'b000001, 1'b1, 0, 3);
        run_instr(2'b01, 6'b000000, 1'b0, 0, 0);
        run_instr(2'b10, 6'b000000, 1'b1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_instr(2'($urandom_range(0, 3)), 6'($urandom),
                      1'($urandom_range(0, 3) != 0),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // watchdog: fetch never completes
        mem_ready = 1'b0; OP = 2'b00;
        k = 0; n = 0;
        while (!fault && k < 40) begin
            if (mem_req) n++;
            @(negedge clk);
            k++;
        end
        chk("wd_wait_cycles", n, 15);
        chk("fault_set", fault, 1);
        mem_ready = 1'b1;
        n = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); #1;
            if (!fault || mem_req || PCWrite || IRWrite || RegW || ImmSrc != 0) n++;
        end
        chk("fault_sticky", n, 0);
        reset_n = 1'b0;
        #1;
        chk("fault_cleared", fault, 0);
        do_reset();
        #1;
        chk("restart_fetch", mem_req, 1);

        // reset during a stalled store
        @(negedge clk);
        OP = 2'b01; Funct = 6'd0; CondEx = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("st_memw", MemW, 1);
        chk("st_req", mem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_memw", MemW, 0);
        chk("rst_async_req", mem_req, 0);
        do_reset();

`ifdef CTRL_PERF_EN
        for (int i = 0; i < 10; i++) run_instr(2'b00, 6'd0, 1'b1, 0, 0);
        chk("perf_instr", instr_count, 10);
        chk("perf_cycle", cycle_count, 40);
`else
        chk("perf_instr_tied", instr_count, 0);
        chk("perf_cycle_tied", cycle_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controllo_multiciclo.md
Name: controllo_multiciclo

Overview:
Multicycle control unit for the ARM-subset datapath. It is the sequential successor of the single-cycle main decoder: the same OP/Funct decode, spread over a Moore FSM that shares one memory and one ALU across cycles. It adds a req/ready memory handshake with wait states, a memory-wait watchdog, and conditional-execution gating. It sits between the instruction register/condition logic and the multicycle datapath.

Parameters:
TIMEOUT_W, 4, width of the memory-wait watchdog counter.
MEM_TIMEOUT, 15, maximum wait cycles per memory access; 0 disables the watchdog.
PERF_W, 32, width of the performance counters (optional feature).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
OP  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
Funct  in  6  Funct[5]=I (immediate), Funct[0]=L (load), Funct[4:1]=cmd.
CondEx  in  1  condition passed, from external condition logic; valid in DECODE.
mem_ready  in  1  memory completes the current access this cycle.
mem_req  out  1  memory access request.
PCWrite  out  1  PC load enable.
AdrSrc  out  1  0=PC, 1=ALU result.
MemW  out  1  memory write request qualifier.
IRWrite  out  1  instruction register load.
RegW  out  1  register file write.
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
ALUSrcA  out  1  0=RD1, 1=PC.
ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4.
ALUOp  out  1  1=decode Funct[4:1], 0=add.
ImmSrc  out  2  equals OP (combinational).
RegSrc  out  2  [0]=(OP==10), [1]=(OP==01 && Funct[0]==0) (combinational).
instr_done  out  1  one-cycle pulse when an instruction retires or is skipped.
fault  out  1  sticky memory-timeout flag.
instr_count  out  PERF_W  retired instructions (optional feature).
cycle_count  out  PERF_W  cycles since reset (optional feature).

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, FAULT. Reset puts the FSM in FETCH, clears the watchdog, and clears fault.
- While reset_n=0: mem_req, MemW, RegW, PCWrite, IRWrite, instr_done are forced 0, combinationally and immediately, including mid-access.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready. Advance to DECODE only on mem_ready; otherwise hold.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - CondEx=0 or OP=11 -> FETCH, with an instr_done pulse and no writes.
  - OP=01 -> MEMADR. OP=10 -> BRANCH.
  - OP=00 -> EXECI if Funct[5]=1, else EXECR.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Funct[0]=1 -> MEMREAD, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegW=1, instr_done=1, -> FETCH.
- MEMWRITE: mem_req=MemW=1, AdrSrc=1. Hold until mem_ready, then instr_done=1, -> FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1, -> ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1, -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1, instr_done=1, -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1, instr_done=1, -> FETCH.
- Unlisted outputs are 0 in every state. All FSM outputs are Moore, except IRWrite/PCWrite in FETCH, which follow mem_ready.
- Latency: data-processing 4 cycles, load 5, store 4, branch 3, skipped 2 (all with zero wait states). Each wait cycle adds 1.
- Watchdog: counts consecutive cycles with mem_req=1 and mem_ready=0; clears on mem_ready or state change.
  - MEM_TIMEOUT>0 and count reaches MEM_TIMEOUT -> FAULT.
  - FAULT: all outputs 0 except fault=1. Left only by reset.
  - Counter saturates; it never wraps.
- mem_ready with mem_req=0 is ignored.

Optional Feature:
CTRL_PERF_EN.
- Defined: instr_count increments on each instr_done; cycle_count increments every cycle outside reset. Both wrap modulo 2^PERF_W and reset to 0.
- Undefined: both ports remain and are tied to 0; no counter flops are synthesised.

Decomposition:
- Package controllo_pkg holds:
  - state enum (4-bit encoding);
  - OP codes (OP_DP=00, OP_MEM=01, OP_BR=10);
  - ResultSrc codes (RES_ALUOUT, RES_DATA, RES_ALURES);
  - ALUSrcB codes (SRCB_RD2, SRCB_IMM, SRCB_4).
- One natural sub-module: mem_watchdog (counter, compare, saturate), instantiated once.

Test Plan:
- ADD reg (OP=00, Funct=000000, CondEx=1, mem_ready=1 always) -> states FETCH, DECODE, EXECR, ALUWB; RegW=1 in cycle 4; instr_done pulses once.
- LDR with 3 wait cycles in MEMREAD (OP=01, Funct[0]=1) -> mem_req=1, AdrSrc=1 held 4 cycles; RegW=1, ResultSrc=01 in the following cycle; total 8 cycles.
- STR, CondEx=0 in DECODE -> returns to FETCH after 2 cycles; MemW never asserted; instr_done=1.
- Branch (OP=10) -> PCWrite=1 with ALUSrcB=01, ResultSrc=10 in cycle 3.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> FAULT entered after 15 wait cycles; fault=1 persists; reset_n low clears it and FSM restarts in FETCH.
- reset_n asserted mid-MEMWRITE -> MemW and mem_req drop the same cycle, without a clock edge. With CTRL_PERF_EN, 10 ADDs with zero waits -> instr_count=10, cycle_count=40.
